// File: rtl/axis_wdata_pkg.sv
// Shared constants for the AXI write-data stage: FSM state indices and
// one-hot encodings, default width parameters and AXI response codes.
package axis_wdata_pkg;

  // Bit positions of each state inside the one-hot state vector
  localparam int ST_IDLE   = 0;
  localparam int ST_SETUP  = 1;
  localparam int ST_ACTIVE = 2;
  localparam int ST_RESP   = 3;
  localparam int ST_DONE   = 4;

  localparam int STATE_COUNT = 5;

  typedef enum logic [STATE_COUNT-1:0] {
    S_IDLE   = 5'b00001,
    S_SETUP  = 5'b00010,
    S_ACTIVE = 5'b00100,
    S_RESP   = 5'b01000,
    S_DONE   = 5'b10000
  } state_t;

  // Default geometry of the stream and the AXI write channel
  localparam int DEF_CONFIG_DWIDTH  = 32;
  localparam int DEF_WIDTH_RATIO    = 8;
  localparam int DEF_CONVERT_SHIFT  = 3;
  localparam int DEF_AXI_LEN_WIDTH  = 8;
  localparam int DEF_AXI_DATA_WIDTH = 256;

  // AXI write response code for a successful transfer
  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/axis_wdata.sv
// AXI write-data stage: takes a transfer length in stream elements, forwards
// the packed upstream words onto the AXI W channel split into fixed-length
// bursts, collects one B response per burst and reports done / error.
module axis_wdata
  import axis_wdata_pkg::*;
#(
  parameter int CONFIG_DWIDTH  = DEF_CONFIG_DWIDTH,
  parameter int WIDTH_RATIO    = DEF_WIDTH_RATIO,
  parameter int CONVERT_SHIFT  = DEF_CONVERT_SHIFT,
  parameter int AXI_LEN_WIDTH  = DEF_AXI_LEN_WIDTH,
  parameter int AXI_DATA_WIDTH = DEF_AXI_DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CONFIG_DWIDTH-1:0]    cfg_length,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [AXI_DATA_WIDTH-1:0]   data,
  input  logic                        data_valid,
  output logic                        data_ready,
  output logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                        axi_wlast,
  output logic                        axi_wvalid,
  input  logic                        axi_wready,
  input  logic [1:0]                  axi_bresp,
  input  logic                        axi_bvalid,
  output logic                        axi_bready,
  output logic                        done,
  output logic                        error
);

  state_t                     state;
  logic [CONFIG_DWIDTH-1:0]   beats;
  logic [CONFIG_DWIDTH-1:0]   bursts;
  logic [CONFIG_DWIDTH-1:0]   total_cnt;
  logic [CONFIG_DWIDTH-1:0]   resp_cnt;
  logic [AXI_LEN_WIDTH-1:0]   burst_cnt;
  logic                       error_q;

  logic                       in_active;
  logic                       last_total;
  logic                       last_burst;
  logic                       beat_fire;
  logic                       resp_fire;
  logic [CONFIG_DWIDTH-1:0]   resp_total;

  // Holding rst low forces every handshake output to its idle value
  // immediately, before the first clock edge has cleared the state.
  assign in_active  = rst & state[ST_ACTIVE];

  // The W channel is a straight pass-through of the upstream stream while
  // a transfer is active; the handshake is combinational in both directions.
  assign axi_wvalid = in_active & data_valid;
  assign data_ready = in_active & axi_wready;
  assign axi_wdata  = data;
  assign axi_wstrb  = '1;

  assign last_total = (total_cnt == beats - CONFIG_DWIDTH'(1));
  assign last_burst = &burst_cnt;
  assign axi_wlast  = in_active & (last_burst | last_total);
  assign beat_fire  = axi_wvalid & axi_wready;

  // Responses are accepted while data is still flowing so that early bursts
  // can complete without waiting for the whole transfer.
  assign axi_bready = rst & (state[ST_ACTIVE] | state[ST_RESP]);
  assign resp_fire  = axi_bvalid & axi_bready;
  assign resp_total = resp_cnt + CONFIG_DWIDTH'(resp_fire);

  assign cfg_ready  = ~rst | state[ST_IDLE];
  assign done       = rst & state[ST_DONE];
  assign error      = rst & error_q;

  // Transfer sequencer: captures the length, sizes the bursts, counts data
  // beats and responses, and raises done once every burst is acknowledged.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      beats     <= '0;
      bursts    <= '0;
      total_cnt <= '0;
      resp_cnt  <= '0;
      burst_cnt <= '0;
      error_q   <= 1'b0;
    end else begin
      if (resp_fire) begin
        resp_cnt <= resp_total;
        if (axi_bresp != RESP_OKAY) begin
          error_q <= 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (cfg_valid) begin
            beats     <= CONFIG_DWIDTH'(({1'b0, cfg_length} +
                         (CONFIG_DWIDTH+1)'(WIDTH_RATIO - 1)) >> CONVERT_SHIFT);
            error_q   <= 1'b0;
            total_cnt <= '0;
            burst_cnt <= '0;
            resp_cnt  <= '0;
            state     <= S_SETUP;
          end
        end

        S_SETUP: begin
          bursts <= CONFIG_DWIDTH'(({1'b0, beats} +
                    (CONFIG_DWIDTH+1)'((1 << AXI_LEN_WIDTH) - 1)) >> AXI_LEN_WIDTH);
          if (beats != '0) begin
            state <= S_ACTIVE;
          end else begin
            state <= S_DONE;
          end
        end

        S_ACTIVE: begin
          if (beat_fire) begin
            total_cnt <= total_cnt + CONFIG_DWIDTH'(1);
            if (axi_wlast) begin
              burst_cnt <= '0;
            end else begin
              burst_cnt <= burst_cnt + AXI_LEN_WIDTH'(1);
            end
            if (last_total) begin
              state <= S_RESP;
            end
          end
        end

        S_RESP: begin
          if (resp_total == bursts) begin
            state <= S_DONE;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_wdata.sv
// Self-checking bench for axis_wdata: a protocol-level reference model is
// compared against the DUT on every cycle, and each directed scenario adds
// hand-computed expectations on beat counts, wlast positions and timing.
module tb_axis_wdata;

  localparam int RATIO = 8;
  localparam int BURST = 256;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  cfg_length = '0;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [255:0] data = '0;
  logic         data_valid = 1'b0;
  logic         data_ready;
  logic [255:0] axi_wdata;
  logic [31:0]  axi_wstrb;
  logic         axi_wlast;
  logic         axi_wvalid;
  logic         axi_wready = 1'b0;
  logic [1:0]   axi_bresp = 2'b00;
  logic         axi_bvalid = 1'b0;
  logic         axi_bready;
  logic         done;
  logic         error;

  int tests_run    = 0;
  int tests_failed = 0;

  // Scenario controls, written only by the stimulus process
  bit check_en  = 1'b0;
  bit throttle  = 1'b0;
  int err_burst = -1;

  // Per-transfer observations, written only by the compare process
  int n_acc    = 0;
  int n_bresp  = 0;
  int cyc      = 0;
  int wl_idx[$];
  int done_cyc = -1;

  typedef enum int {M_IDLE, M_SETUP, M_SEND, M_WAIT, M_FINISH} mphase_t;
  mphase_t ph = M_IDLE;
  longint  mbeats = 0;
  longint  mbursts = 0;
  longint  sent = 0;
  longint  got = 0;
  bit      merr = 1'b0;

  axis_wdata dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_length (cfg_length),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .axi_wdata  (axi_wdata),
    .axi_wstrb  (axi_wstrb),
    .axi_wlast  (axi_wlast),
    .axi_wvalid (axi_wvalid),
    .axi_wready (axi_wready),
    .axi_bresp  (axi_bresp),
    .axi_bvalid (axi_bvalid),
    .axi_bready (axi_bready),
    .done       (done),
    .error      (error)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  function automatic logic [255:0] gen_word(input int k);
    logic [31:0] tag;
    tag = 32'hA5A50000 ^ 32'(k);
    return {8{tag}};
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Upstream source and AXI slave: feeds numbered words, optionally
  // throttles valid/ready, and returns one B response per wlast beat.
  initial begin
    logic [1:0] pend[$];
    int  src_idx;
    int  nburst;
    bit  acc, wl, rst_seen, cfg_acc, dacc;
    src_idx = 0;
    nburst  = 0;
    forever begin
      @(negedge clk);
      acc      = axi_bvalid && axi_bready;
      wl       = axi_wvalid && axi_wready && axi_wlast;
      rst_seen = !rst;
      cfg_acc  = cfg_valid && cfg_ready;
      dacc     = data_valid && data_ready;
      @(posedge clk);
      #1;
      if (rst_seen) begin
        pend.delete();
        nburst  = 0;
        src_idx = 0;
      end else begin
        if (cfg_acc) begin
          src_idx = 0;
          nburst  = 0;
        end
        if (acc && pend.size() > 0) void'(pend.pop_front());
        if (wl) begin
          pend.push_back((nburst == err_burst) ? 2'b10 : 2'b00);
          nburst++;
        end
        if (dacc) src_idx++;
      end
      axi_bvalid = (pend.size() > 0);
      axi_bresp  = 2'b00;
      if (pend.size() > 0) axi_bresp = pend[0];
      data       = gen_word(src_idx);
      data_valid = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      axi_wready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Reference model and per-cycle comparison against the DUT outputs
  initial begin
    logic e_cfg, e_wv, e_dr, e_wl, e_br, e_done, e_err;
    forever begin
      @(negedge clk);
      if (!rst) begin
        e_cfg = 1'b1; e_wv = 1'b0; e_dr = 1'b0; e_wl = 1'b0;
        e_br = 1'b0; e_done = 1'b0; e_err = 1'b0;
      end else begin
        e_cfg  = (ph == M_IDLE);
        e_wv   = (ph == M_SEND) && data_valid;
        e_dr   = (ph == M_SEND) && axi_wready;
        e_wl   = (ph == M_SEND) && (((sent % BURST) == BURST - 1) || (sent == mbeats - 1));
        e_br   = (ph == M_SEND) || (ph == M_WAIT);
        e_done = (ph == M_FINISH);
        e_err  = merr;
      end

      if (check_en) begin
        checkOutput("cfg_ready", 256'(cfg_ready), 256'(e_cfg));
        checkOutput("axi_wvalid", 256'(axi_wvalid), 256'(e_wv));
        checkOutput("data_ready", 256'(data_ready), 256'(e_dr));
        checkOutput("axi_wlast", 256'(axi_wlast), 256'(e_wl));
        checkOutput("axi_bready", 256'(axi_bready), 256'(e_br));
        checkOutput("done", 256'(done), 256'(e_done));
        checkOutput("error", 256'(error), 256'(e_err));
        checkOutput("axi_wstrb", 256'(axi_wstrb), 256'(32'hFFFF_FFFF));
        if (e_wv && axi_wvalid) checkOutput("axi_wdata", axi_wdata, gen_word(int'(sent)));

        if (rst && cfg_valid && cfg_ready) begin
          cyc     = 0;
          n_acc   = 0;
          n_bresp = 0;
          wl_idx.delete();
        end else begin
          cyc++;
        end
        if (axi_wvalid && axi_wready) begin
          if (axi_wlast) wl_idx.push_back(n_acc);
          n_acc++;
        end
        if (axi_bvalid && axi_bready) n_bresp++;
      end

      if (!rst) begin
        ph = M_IDLE; merr = 1'b0; sent = 0; got = 0;
      end else begin
        case (ph)
          M_IDLE: if (cfg_valid) begin
            mbeats  = (longint'(cfg_length) + RATIO - 1) / RATIO;
            mbursts = (mbeats + BURST - 1) / BURST;
            merr = 1'b0; sent = 0; got = 0;
            ph = M_SETUP;
          end
          M_SETUP: ph = (mbeats == 0) ? M_FINISH : M_SEND;
          M_SEND: begin
            if (axi_bvalid) begin
              got++;
              if (axi_bresp != 2'b00) merr = 1'b1;
            end
            if (data_valid && axi_wready) begin
              if (sent == mbeats - 1) ph = M_WAIT;
              sent++;
            end
          end
          M_WAIT: begin
            if (axi_bvalid) begin
              got++;
              if (axi_bresp != 2'b00) merr = 1'b1;
            end
            if (got == mbursts) ph = M_FINISH;
          end
          M_FINISH: ph = M_IDLE;
          default: ph = M_IDLE;
        endcase
      end
    end
  end

  task automatic launchCfg(input int len, input int ebur, input bit thr);
    @(posedge clk);
    #1;
    err_burst  = ebur;
    throttle   = thr;
    cfg_length = 32'(len);
    cfg_valid  = 1'b1;
    @(posedge clk);
    #1;
    cfg_valid  = 1'b0;
  endtask

  task automatic waitDone(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        done_cyc = cyc;
        break;
      end
    end
    checkOutput({name, "_done_seen"}, 256'(seen), 256'(1));
    throttle = 1'b0;
  endtask

  task automatic applyStimulus(input string name, input int len, input int ebur, input bit thr);
    launchCfg(len, ebur, thr);
    waitDone(name);
  endtask

  // Directed scenarios with hand-computed expectations
  initial begin
    int acc_at_reset;
    bit seen_bad;

    @(posedge clk);
    #1;
    check_en = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("rst_cfg_ready", 256'(cfg_ready), 256'(1));
    checkOutput("rst_data_ready", 256'(data_ready), 256'(0));
    checkOutput("rst_wvalid", 256'(axi_wvalid), 256'(0));
    checkOutput("rst_done", 256'(done), 256'(0));
    checkOutput("rst_error", 256'(error), 256'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;

    // 16 elements -> 2 beats, one burst, last on the second beat
    applyStimulus("len16", 16, -1, 1'b0);
    checkOutput("len16_beats", 256'(n_acc), 256'(2));
    checkOutput("len16_wlast_cnt", 256'(wl_idx.size()), 256'(1));
    checkOutput("len16_wlast_pos", 256'((wl_idx.size() > 0) ? wl_idx[0] : -1), 256'(1));
    checkOutput("len16_bresp", 256'(n_bresp), 256'(1));
    checkOutput("len16_error", 256'(error), 256'(0));

    // 2056 elements -> 257 beats, bursts of 256 and 1
    applyStimulus("len2056", 2056, -1, 1'b0);
    checkOutput("len2056_beats", 256'(n_acc), 256'(257));
    checkOutput("len2056_wlast_cnt", 256'(wl_idx.size()), 256'(2));
    checkOutput("len2056_wlast_a", 256'((wl_idx.size() > 0) ? wl_idx[0] : -1), 256'(255));
    checkOutput("len2056_wlast_b", 256'((wl_idx.size() > 1) ? wl_idx[1] : -1), 256'(256));
    checkOutput("len2056_bresp", 256'(n_bresp), 256'(2));

    // Zero length: no data, done in the third cycle counting the cfg_valid cycle
    applyStimulus("len0", 0, -1, 1'b0);
    checkOutput("len0_beats", 256'(n_acc), 256'(0));
    checkOutput("len0_done_cycle", 256'(done_cyc), 256'(2));

    // 2400 elements -> 300 beats under random valid/ready throttling
    applyStimulus("thr300", 2400, -1, 1'b1);
    checkOutput("thr300_beats", 256'(n_acc), 256'(300));
    checkOutput("thr300_bresp", 256'(n_bresp), 256'(2));

    // SLVERR on the second burst sets error; the next configuration clears it
    applyStimulus("slverr", 2056, 1, 1'b0);
    checkOutput("slverr_err_at_done", 256'(error), 256'(1));
    @(negedge clk);
    #1;
    checkOutput("slverr_err_idle", 256'(error), 256'(1));
    launchCfg(16, -1, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("slverr_err_cleared", 256'(error), 256'(0));
    waitDone("after_err");

    // Reset in the middle of a 300-beat transfer
    launchCfg(2400, -1, 1'b0);
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      #1;
      if (n_acc >= 100) break;
    end
    checkOutput("abort_reached_100", 256'(n_acc >= 100), 256'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("abort_cfg_ready", 256'(cfg_ready), 256'(1));
    checkOutput("abort_data_ready", 256'(data_ready), 256'(0));
    checkOutput("abort_wvalid", 256'(axi_wvalid), 256'(0));
    checkOutput("abort_wlast", 256'(axi_wlast), 256'(0));
    checkOutput("abort_bready", 256'(axi_bready), 256'(0));
    acc_at_reset = n_acc;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("abort_cfg_ready_after", 256'(cfg_ready), 256'(1));
    seen_bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (done || axi_wvalid) seen_bad = 1'b1;
    end
    checkOutput("abort_quiet", 256'(seen_bad), 256'(0));
    checkOutput("abort_no_beats", 256'(n_acc), 256'(acc_at_reset));

    // Recovery after the abort
    applyStimulus("recover", 16, -1, 1'b0);
    checkOutput("recover_beats", 256'(n_acc), 256'(2));

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
